// File: rtl/vmicro16_uart_rx_apb_pkg.sv
// Shared SoC configuration for the APB UART receiver: register offsets, STATUS
// bit positions, default bit period, receiver state encoding and STATUS packing.
package vmicro16_uart_rx_apb_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME     = 3;
  localparam int STAT_PARITY    = 4;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef struct packed {
    logic parity;
    logic frame;
    logic overrun;
  } sticky_t;

  function automatic logic [15:0] pack_status(
    input logic                    not_empty,
    input logic                    full,
    input sticky_t                 flags,
    input logic [STAT_COUNT_W-1:0] count
  );
    logic [15:0] s;
    s = '0;
    s[STAT_NOT_EMPTY] = not_empty;
    s[STAT_FULL]      = full;
    s[STAT_OVERRUN]   = flags.overrun;
    s[STAT_FRAME]     = flags.frame;
    s[STAT_PARITY]    = flags.parity;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/vmicro16_fifo.sv
// Synchronous FIFO; a pop on a full FIFO frees the slot so a simultaneous push
// is accepted. Pop on empty and push on full (without pop) are ignored.
module vmicro16_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver (8 data bits, 1 stop bit) with receive FIFO and sticky
// error flags. Define APB_UART_RX_PARITY_EN to receive one even-parity bit.
module vmicro16_uart_rx_apb
  import vmicro16_uart_rx_apb_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  sticky_t          flags_q, flags_d;

  logic             rx_s;
  logic             bit_done;
  logic             rx_push, frame_set, parity_set, overrun_set;
  logic             apb_access, apb_pop, apb_clear;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic [15:0]      status;
  logic             unused_bits;

  assign sync_d   = {sync_q[0], rx_wire};
  assign rx_s     = sync_q[1];
  assign bit_done = (cnt_q == BIT_LAST);

  // Receiver FSM: all sample points are at bit centres, timed from the start-bit midpoint.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        if (bit_done) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef APB_UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef APB_UART_RX_PARITY_EN
      RX_PARITY: begin
        cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        if (bit_done) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_bad_d  = (rx_s != ^shift_q);
          parity_set = (rx_s != ^shift_q);
          state_d    = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        if (bit_done) begin
          if (rx_s) begin
            rx_push = ~par_bad_q;
            state_d = RX_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // APB decode: zero wait states, pop only in the access phase of a DATA read.
  assign apb_access = S_PSELx & S_PENABLE;
  assign S_PREADY   = apb_access;
  assign apb_pop    = apb_access & ~S_PWRITE & (S_PADDR[1:0] == REG_DATA) & ~reset;
  assign apb_clear  = apb_access & S_PWRITE & (S_PADDR[1:0] == REG_CLEAR);

  // A full FIFO only drops the byte when no pop frees a slot in the same cycle.
  assign overrun_set = rx_push & fifo_full & ~apb_pop;

  // Sticky flags: a set in the same cycle as a CLEAR wins.
  always_comb begin
    flags_d.overrun = overrun_set |
                      (flags_q.overrun & ~(apb_clear & S_PWDATA[STAT_OVERRUN]));
    flags_d.frame   = frame_set |
                      (flags_q.frame & ~(apb_clear & S_PWDATA[STAT_FRAME]));
`ifdef APB_UART_RX_PARITY_EN
    flags_d.parity  = parity_set |
                      (flags_q.parity & ~(apb_clear & S_PWDATA[STAT_PARITY]));
`else
    flags_d.parity  = parity_set;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      flags_q   <= flags_d;
    end
  end

  vmicro16_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (apb_pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign status = pack_status(~fifo_empty, fifo_full, flags_q,
                              STAT_COUNT_W'(fifo_count));

  // Read mux is zero whenever the slave is not selected so buses can OR slaves together.
  always_comb begin
    S_PRDATA = '0;
    if (S_PSELx) begin
      case (S_PADDR[1:0])
        REG_DATA:   if (!reset && !fifo_empty) S_PRDATA = BUS_WIDTH'({8'h00, fifo_dout});
        REG_STATUS: S_PRDATA = BUS_WIDTH'(status);
        default:    S_PRDATA = '0;
      endcase
    end
  end

  assign unused_bits = ^{S_PADDR, S_PWDATA};

endmodule
